// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: parametrised register file with two registered read ports,
// one write port with same-cycle write-to-read bypass, and a per-register
// pending scoreboard used by issue logic to detect read-after-write hazards.
module reg_file_2r1w #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid1,
  output logic              rd_valid2,
  output logic              rd_pend1,
  output logic              rd_pend2,
  output logic [DEPTH-1:0]  pend_vec
);

  // One extra bit so DEPTH=2**ADDR_W (e.g. 256) still fits for the compare.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  // An address is usable when it names an existing register that is not the
  // hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = ({1'b0, a} < DEPTH_LIM) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic              wr_ok;
  logic              rsv_ok;
  logic [DEPTH-1:0]  wr_dec;
  logic [DEPTH-1:0]  rsv_dec;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] rd_nxt1;
  logic [DATA_W-1:0] rd_nxt2;
  logic              pnd_nxt1;
  logic              pnd_nxt2;

  assign wr_ok  = wr_en  && addr_ok(wr_addr);
  assign rsv_ok = rsv_en && addr_ok(rsv_addr);
  assign hit1   = wr_ok && (wr_addr == rd_addr1);
  assign hit2   = wr_ok && (wr_addr == rd_addr2);

  // One-hot decode of the legal write and reserve targets.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the un-assigned paths would infer latches.
    wr_dec  = '0;
    rsv_dec = '0;
    if (wr_ok)  wr_dec[wr_addr]   = 1'b1;
    if (rsv_ok) rsv_dec[rsv_addr] = 1'b1;
  end

  // Port 1 read value and hazard: bypass a same-cycle write, zero if illegal.
  always_comb begin
    rd_nxt1  = '0;
    pnd_nxt1 = 1'b0;
    if (addr_ok(rd_addr1)) begin
      rd_nxt1  = hit1 ? wr_data : mem[rd_addr1];
      pnd_nxt1 = pend[rd_addr1] && !hit1;
    end
  end

  // Port 2 read value and hazard, identical rules to port 1.
  always_comb begin
    rd_nxt2  = '0;
    pnd_nxt2 = 1'b0;
    if (addr_ok(rd_addr2)) begin
      rd_nxt2  = hit2 ? wr_data : mem[rd_addr2];
      pnd_nxt2 = pend[rd_addr2] && !hit2;
    end
  end

  // Storage array write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is cleared on reset because reads after reset must
      // return zero; this costs a reset net on every flop but is required.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: a write clears its bit, a reservation sets it; set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      pend <= '0;
    end else begin
      pend <= (pend & ~wr_dec) | rsv_dec;
    end
  end

  // Read output registers; data and hazard hold while the port is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data1  <= '0;
      rd_data2  <= '0;
      rd_pend1  <= 1'b0;
      rd_pend2  <= 1'b0;
      rd_valid1 <= 1'b0;
      rd_valid2 <= 1'b0;
    end else begin
      rd_valid1 <= rd_en1;
      rd_valid2 <= rd_en2;
      if (rd_en1) begin
        rd_data1 <= rd_nxt1;
        rd_pend1 <= pnd_nxt1;
      end
      if (rd_en2) begin
        rd_data2 <= rd_nxt2;
        rd_pend2 <= pnd_nxt2;
      end
    end
  end

  assign pend_vec = pend;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Testbench for reg_file_2r1w (DEPTH=20, ZERO_REG=1): directed scenarios
// followed by random traffic, all checked against a behavioural model.
module tb_reg_file_2r1w;

  localparam int DW = 32;
  localparam int DP = 20;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en, rsv_en, rd_en1, rd_en2;
  logic [AW-1:0] wr_addr, rsv_addr, rd_addr1, rd_addr2;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2, rd_pend1, rd_pend2;
  logic [DP-1:0] pend_vec;

  int tests = 0;
  int fails = 0;

  // Reference model state and expected outputs.
  logic [DW-1:0] m_mem [DP];
  bit            m_pend [DP];
  logic [DW-1:0] e_data1, e_data2;
  logic          e_valid1, e_valid2, e_pend1, e_pend2;

  reg_file_2r1w #(.DATA_W(DW), .DEPTH(DP), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1),
    .rd_en2(rd_en2), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_valid1(rd_valid1), .rd_valid2(rd_valid2),
    .rd_pend1(rd_pend1), .rd_pend2(rd_pend2),
    .pend_vec(pend_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int a);
    return (a < DP) && (a != 0);
  endfunction

  function automatic logic [DP-1:0] exp_vec();
    logic [DP-1:0] v;
    for (int i = 0; i < DP; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] model_read(input int a);
    if (!legal(a)) return '0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic model_hazard(input int a);
    if (!legal(a)) return 1'b0;
    return m_pend[a] && !(wr_en && int'(wr_addr) == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DP; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    e_data1 = '0; e_data2 = '0;
    e_valid1 = 1'b0; e_valid2 = 1'b0;
    e_pend1 = 1'b0; e_pend2 = 1'b0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    if (rd_en1) begin e_data1 = model_read(int'(rd_addr1)); e_pend1 = model_hazard(int'(rd_addr1)); end
    if (rd_en2) begin e_data2 = model_read(int'(rd_addr2)); e_pend2 = model_hazard(int'(rd_addr2)); end
    e_valid1 = rd_en1;
    e_valid2 = rd_en2;
    if (wr_en && legal(int'(wr_addr))) begin
      m_mem[wr_addr]  = wr_data;
      m_pend[wr_addr] = 1'b0;
    end
    if (rsv_en && legal(int'(rsv_addr))) m_pend[rsv_addr] = 1'b1;
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".rd_data1"},  rd_data1,  e_data1);
    check({ctx, ".rd_data2"},  rd_data2,  e_data2);
    check({ctx, ".rd_valid1"}, rd_valid1, e_valid1);
    check({ctx, ".rd_valid2"}, rd_valid2, e_valid2);
    check({ctx, ".rd_pend1"},  rd_pend1,  e_pend1);
    check({ctx, ".rd_pend2"},  rd_pend2,  e_pend2);
    check({ctx, ".pend_vec"},  pend_vec,  exp_vec());
  endtask

  task automatic drive(input logic we, input int wa, input logic [DW-1:0] wd,
                       input logic re, input int ra,
                       input logic e1, input int a1, input logic e2, input int a2);
    wr_en = we;  wr_addr = AW'(wa);  wr_data = wd;
    rsv_en = re; rsv_addr = AW'(ra);
    rd_en1 = e1; rd_addr1 = AW'(a1);
    rd_en2 = e2; rd_addr2 = AW'(a2);
  endtask

  task automatic step(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  // Assert reset in the middle of a cycle, check outputs cleared at once.
  task automatic mid_reset(input string ctx);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0);
    #3;
    check_all("reset_init");
    #9 rst_n = 1'b1;

    // Reset clears storage written beforehand.
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0); step("wr_r5");
    drive(0, 0, '0, 0, 0, 1, 5, 0, 0);           step("rd_r5");
    check("rd_r5_before_reset", rd_data1, 32'hDEADBEEF);
    mid_reset("async_reset");
    drive(0, 0, '0, 0, 0, 1, 5, 0, 0);           step("rd_r5_after");
    check("r5_after_reset", rd_data1, 32'h0);
    check("r5_pend_after_reset", rd_pend1, 1'b0);

    // Write-to-read bypass, then hold.
    drive(1, 7, 32'h12345678, 0, 0, 1, 7, 0, 0); step("bypass");
    check("bypass_data", rd_data1, 32'h12345678);
    check("bypass_valid", rd_valid1, 1'b1);
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0);           step("hold");
    check("hold_data", rd_data1, 32'h12345678);
    check("hold_valid", rd_valid1, 1'b0);

    // Zero register ignores writes and reservations.
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0); step("zero_wr");
    drive(0, 0, '0, 0, 0, 1, 0, 1, 0);           step("zero_rd");
    check("zero_data1", rd_data1, 32'h0);
    check("zero_data2", rd_data2, 32'h0);
    check("zero_pend_vec0", pend_vec[0], 1'b0);

    // Scoreboard set and clear with same-cycle read.
    drive(0, 0, '0, 1, 3, 0, 0, 0, 0);           step("rsv_r3");
    drive(0, 0, '0, 0, 0, 1, 3, 0, 0);           step("rd_r3");
    check("r3_pending", rd_pend1, 1'b1);
    check("r3_pend_vec", pend_vec, 20'h00008);
    drive(1, 3, 32'hA5, 0, 0, 1, 3, 0, 0);       step("wr_rd_r3");
    check("r3_data", rd_data1, 32'hA5);
    check("r3_hazard_cleared", rd_pend1, 1'b0);
    check("r3_pend_vec_clr", pend_vec, 20'h0);

    // Write, reserve and read of the same pending register in one cycle.
    drive(0, 0, '0, 1, 9, 0, 0, 0, 0);           step("rsv_r9");
    drive(1, 9, 32'h55, 1, 9, 0, 0, 1, 9);       step("simul_r9");
    check("r9_data2", rd_data2, 32'h55);
    check("r9_pend2", rd_pend2, 1'b0);
    check("r9_still_pending", pend_vec[9], 1'b1);

    // Addresses beyond a non-power-of-two depth.
    drive(1, 25, 32'hCAFEF00D, 1, 25, 1, 25, 0, 0); step("addr25");
    check("addr25_data", rd_data1, 32'h0);
    drive(1, 19, 32'h77, 0, 0, 0, 0, 0, 0);      step("wr_r19");
    drive(0, 0, '0, 0, 0, 1, 19, 1, 19);         step("rd_r19");
    check("r19_data1", rd_data1, 32'h77);
    check("r19_data2", rd_data2, 32'h77);

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom,
            ($urandom_range(0, 3) == 0), $urandom_range(0, 31),
            $urandom_range(0, 1), $urandom_range(0, 23),
            $urandom_range(0, 1), $urandom_range(0, 23));
      step("rand");
      if ($urandom_range(0, 99) == 0) mid_reset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
